// File: rtl/uc_seq.sv
// uc_seq: sequenced control unit for the 8-opcode micro datapath.
// Accepts one instruction per handshake, decodes it into registered
// register-file / move / ALU / jump controls, holds them for an EXEC cycle
// and, for LOAD_1, MOVE and MATH, a further WB cycle with o_Wr_En=1.
// Keeps its own program counter and takes conditional jumps on ALU flags.
//
// Handshake: o_Ready is high only in FETCH and never while i_Rst is high.
// An instruction is accepted on a rising edge where o_Ready && i_Instr_Valid;
// opcode and arguments are captured on that edge. While o_Ready is low,
// i_Instr_Valid and the instruction inputs are ignored.
//
// Ports:
//   i_Clk, i_Rst            clock, synchronous active-high reset
//   i_Instr_Valid           instruction present on i_Cod_op / i_Arguments
//   i_Cod_op[2:0]           opcode
//   i_Arguments[ARG_W-1:0]  A = high half, B = low half
//   i_Flags[1:0]            [0] Z, [1] C from the ALU
//   o_Ready                 able to accept an instruction
//   o_PC[PC_W-1:0]          program counter (drives instruction memory)
//   o_Lec_RX, o_Lec_RY, o_Sel_Esc, o_D1, o_D2, o_ALU_Op   F-bit fields
//   o_Sel_LyE, o_Move, o_Math_En, o_Jump, o_Wr_En        strobes
//   o_State[1:0]            debug view of the sequencer state
module uc_seq #(
  parameter int ARG_W = 6,
  parameter int PC_W  = 8
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_Instr_Valid,
  input  logic [2:0]           i_Cod_op,
  input  logic [ARG_W-1:0]     i_Arguments,
  input  logic [1:0]           i_Flags,
  output logic                 o_Ready,
  output logic [PC_W-1:0]      o_PC,
  output logic [ARG_W/2-1:0]   o_Lec_RX,
  output logic [ARG_W/2-1:0]   o_Lec_RY,
  output logic [ARG_W/2-1:0]   o_Sel_Esc,
  output logic [ARG_W/2-1:0]   o_D1,
  output logic [ARG_W/2-1:0]   o_D2,
  output logic [ARG_W/2-1:0]   o_ALU_Op,
  output logic                 o_Sel_LyE,
  output logic                 o_Move,
  output logic                 o_Math_En,
  output logic                 o_Jump,
  output logic                 o_Wr_En,
  output logic [1:0]           o_State
);

  localparam int F = ARG_W / 2;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2
  } state_t;

  typedef struct packed {
    logic [F-1:0] lec_rx;
    logic [F-1:0] lec_ry;
    logic [F-1:0] sel_esc;
    logic [F-1:0] d1;
    logic [F-1:0] d2;
    logic [F-1:0] alu_op;
    logic         sel_lye;
    logic         move;
    logic         math_en;
  } ctrl_t;

  state_t          state;
  ctrl_t           ctrl;
  ctrl_t           dec;
  logic            dec_wb;
  logic            dec_jmp;
  logic            wr_en;
  logic            has_wb;
  logic            jmp_pend;
  logic [1:0]      jmp_cond;
  logic [PC_W-1:0] jmp_tgt;
  logic [PC_W-1:0] pc;
  logic            jmp_hit;
  logic            jmp_take;

  logic [F-1:0] arg_a;
  logic [F-1:0] arg_b;
  assign arg_a = i_Arguments[ARG_W-1:F];
  assign arg_b = i_Arguments[F-1:0];

  // Decode of the instruction on the input bus; only used on the accept edge.
  always_comb begin
    dec     = '0;
    dec_wb  = 1'b0;
    dec_jmp = 1'b0;
    case (i_Cod_op)
      3'd0: begin dec.lec_rx = arg_a; dec.sel_esc = arg_b; dec.sel_lye = 1'b1; dec_wb = 1'b1; end
      3'd1: begin dec.lec_rx = arg_a; dec.lec_ry  = arg_b; end
      3'd2: begin dec.lec_rx = arg_a; dec.sel_esc = arg_b; end
      3'd3: begin dec.lec_rx = arg_a; dec.lec_ry  = arg_b; dec.sel_lye = 1'b1; end
      3'd4: begin dec.d1 = arg_a; dec.d2 = arg_b; dec.move = 1'b1; dec_wb = 1'b1; end
      3'd5: begin dec.alu_op = arg_b; dec.sel_esc = arg_a; dec.math_en = 1'b1; dec_wb = 1'b1; end
      3'd6: dec_jmp = 1'b1;
      default: ;
    endcase
  end

  // Jump condition evaluated against the flags present during EXEC.
  always_comb begin
    case (jmp_cond)
      2'b00:   jmp_hit = 1'b1;
      2'b01:   jmp_hit = i_Flags[0];
      2'b10:   jmp_hit = i_Flags[1];
      default: jmp_hit = !i_Flags[0];
    endcase
  end

  // jmp_pend is a register that is high only in the EXEC cycle of a JUMP,
  // so o_Jump is a single-cycle pulse gated by the live EXEC flags.
  assign jmp_take = jmp_pend && jmp_hit;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state    <= S_FETCH;
      ctrl     <= '0;
      wr_en    <= 1'b0;
      has_wb   <= 1'b0;
      jmp_pend <= 1'b0;
      jmp_cond <= 2'b00;
      jmp_tgt  <= '0;
      pc       <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (i_Instr_Valid) begin
            state    <= S_EXEC;
            ctrl     <= dec;
            has_wb   <= dec_wb;
            jmp_pend <= dec_jmp;
            jmp_cond <= i_Arguments[ARG_W-1:ARG_W-2];
            jmp_tgt  <= PC_W'(i_Arguments[ARG_W-3:0]);
          end
        end
        S_EXEC: begin
          jmp_pend <= 1'b0;
          if (has_wb) begin
            state <= S_WB;
            wr_en <= 1'b1;
          end else begin
            state <= S_FETCH;
            ctrl  <= '0;
            pc    <= jmp_take ? jmp_tgt : pc + PC_W'(1);
          end
        end
        S_WB: begin
          state <= S_FETCH;
          ctrl  <= '0;
          wr_en <= 1'b0;
          pc    <= pc + PC_W'(1);
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  assign o_Ready   = (state == S_FETCH) && !i_Rst;
  assign o_PC      = pc;
  assign o_Lec_RX  = ctrl.lec_rx;
  assign o_Lec_RY  = ctrl.lec_ry;
  assign o_Sel_Esc = ctrl.sel_esc;
  assign o_D1      = ctrl.d1;
  assign o_D2      = ctrl.d2;
  assign o_ALU_Op  = ctrl.alu_op;
  assign o_Sel_LyE = ctrl.sel_lye;
  assign o_Move    = ctrl.move;
  assign o_Math_En = ctrl.math_en;
  assign o_Jump    = jmp_take;
  assign o_Wr_En   = wr_en;
  assign o_State   = state;

endmodule

// File: tb/tb_uc_seq.sv
// Testbench for uc_seq with default parameters (ARG_W=6, PC_W=8).
module tb_uc_seq;

  logic       clk;
  logic       i_Rst;
  logic       i_Instr_Valid;
  logic [2:0] i_Cod_op;
  logic [5:0] i_Arguments;
  logic [1:0] i_Flags;
  logic       o_Ready;
  logic [7:0] o_PC;
  logic [2:0] o_Lec_RX, o_Lec_RY, o_Sel_Esc, o_D1, o_D2, o_ALU_Op;
  logic       o_Sel_LyE, o_Move, o_Math_En, o_Jump, o_Wr_En;
  logic [1:0] o_State;

  uc_seq #(.ARG_W(6), .PC_W(8)) dut (
    .i_Clk(clk), .i_Rst(i_Rst), .i_Instr_Valid(i_Instr_Valid),
    .i_Cod_op(i_Cod_op), .i_Arguments(i_Arguments), .i_Flags(i_Flags),
    .o_Ready(o_Ready), .o_PC(o_PC),
    .o_Lec_RX(o_Lec_RX), .o_Lec_RY(o_Lec_RY), .o_Sel_Esc(o_Sel_Esc),
    .o_D1(o_D1), .o_D2(o_D2), .o_ALU_Op(o_ALU_Op),
    .o_Sel_LyE(o_Sel_LyE), .o_Move(o_Move), .o_Math_En(o_Math_En),
    .o_Jump(o_Jump), .o_Wr_En(o_Wr_En), .o_State(o_State)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL timeout cyc=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  // all control outputs packed in one vector, wr_en in bit 0
  logic [22:0] act;
  assign act = {o_Lec_RX, o_Lec_RY, o_Sel_Esc, o_D1, o_D2, o_ALU_Op,
                o_Sel_LyE, o_Move, o_Math_En, o_Jump, o_Wr_En};

  int total = 0;
  int bad   = 0;
  int exp_pc = 0;
  logic [2:0] s_rx, s_esc, s_alu;
  logic       s_jump;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference model: behaviour written from the opcode rules
  function automatic bit jump_taken(input int arg, input logic [1:0] fl);
    int c;
    c = arg / 16;
    return (c == 0) || (c == 1 && fl[0]) || (c == 2 && fl[1]) || (c == 3 && !fl[0]);
  endfunction

  function automatic logic [22:0] model_ctrl(input int op, input int arg, input logic [1:0] fl);
    int a, b, rx, ry, esc, d1, d2, alu, lye, mv, me, jp;
    a = arg / 8; b = arg % 8;
    rx = 0; ry = 0; esc = 0; d1 = 0; d2 = 0; alu = 0; lye = 0; mv = 0; me = 0; jp = 0;
    case (op)
      0: begin rx = a; esc = b; lye = 1; end
      1: begin rx = a; ry = b; end
      2: begin rx = a; esc = b; end
      3: begin rx = a; ry = b; lye = 1; end
      4: begin d1 = a; d2 = b; mv = 1; end
      5: begin alu = b; esc = a; me = 1; end
      6: jp = int'(jump_taken(arg, fl));
      default: ;
    endcase
    return {3'(rx), 3'(ry), 3'(esc), 3'(d1), 3'(d2), 3'(alu),
            1'(lye), 1'(mv), 1'(me), 1'(jp), 1'b0};
  endfunction

  task automatic do_reset();
    i_Rst = 1'b1;
    i_Instr_Valid = 1'b0;
    step();
    step();
    chk("rst_ctrl", act, 0);
    chk("rst_pc", o_PC, 0);
    chk("rst_ready_low", o_Ready, 0);
    i_Rst = 1'b0;
    #1;
    chk("rst_ready_after", o_Ready, 1);
    exp_pc = 0;
  endtask

  // driver: issue one instruction and follow it through to FETCH
  task automatic run_instr(input int op, input int arg, input logic [1:0] fl);
    logic [22:0] e;
    bit wb;
    int n;
    n = 0;
    while (!o_Ready && n < 8) begin step(); n++; end
    chk("ready_before_accept", o_Ready, 1);
    i_Instr_Valid = 1'b1;
    i_Cod_op = 3'(op);
    i_Arguments = 6'(arg);
    i_Flags = fl;
    e = model_ctrl(op, arg, fl);
    wb = (op == 0 || op == 4 || op == 5);
    step();
    // scramble the bus mid-EXEC; it must be ignored
    i_Cod_op = 3'($urandom_range(0, 7));
    i_Arguments = 6'($urandom_range(0, 63));
    i_Instr_Valid = 1'($urandom_range(0, 1));
    s_rx = o_Lec_RX; s_esc = o_Sel_Esc; s_alu = o_ALU_Op; s_jump = o_Jump;
    chk("exec_ctrl", act, e);
    chk("exec_ready", o_Ready, 0);
    chk("exec_pc", o_PC, exp_pc);
    if (wb) begin
      step();
      chk("wb_ctrl", act, e | 23'd1);
      chk("wb_ready", o_Ready, 0);
    end
    step();
    i_Instr_Valid = 1'b0;
    if (op == 6 && jump_taken(arg, fl)) exp_pc = arg % 16;
    else exp_pc = (exp_pc + 1) % 256;
    chk("done_ctrl", act, 0);
    chk("done_pc", o_PC, exp_pc);
    chk("done_ready", o_Ready, 1);
  endtask

  int ops[4]  = '{7, 3, 4, 7};
  int args[4] = '{5, 6'b010011, 6'b110110, 9};
  int acc_t[4];
  int k, n, p0, pc_at4;
  logic rdy;

  initial begin
    i_Rst = 1'b1; i_Instr_Valid = 1'b0; i_Cod_op = '0; i_Arguments = '0; i_Flags = '0;
    do_reset();

    // LOAD_1 101011
    run_instr(0, 6'b101011, 2'b00);
    chk("load1_rx", s_rx, 5);
    chk("load1_esc", s_esc, 3);
    chk("load1_pc", o_PC, 1);

    // MATH 010110
    run_instr(5, 6'b010110, 2'b00);
    chk("math_alu", s_alu, 6);
    chk("math_esc", s_esc, 2);

    // JUMP cond Z, target 9
    run_instr(6, 6'b011001, 2'b00);
    chk("jz_not_taken", s_jump, 0);
    run_instr(6, 6'b011001, 2'b01);
    chk("jz_taken", s_jump, 1);
    chk("jz_pc", o_PC, 9);
    run_instr(6, 6'b000011, 2'($urandom_range(0, 3)));
    chk("jalways_pc", o_PC, 3);
    run_instr(6, 6'b100111, 2'b00);
    chk("jc_not_taken", s_jump, 0);
    run_instr(6, 6'b100111, 2'b10);
    chk("jc_pc", o_PC, 7);
    run_instr(6, 6'b110101, 2'b01);
    chk("jnz_not_taken", s_jump, 0);
    run_instr(6, 6'b110101, 2'b00);
    chk("jnz_pc", o_PC, 5);

    // back-to-back with valid held high: NOP, STORE_2, MOVE, NOP
    p0 = exp_pc; k = 0; n = 0; pc_at4 = -1;
    i_Instr_Valid = 1'b1;
    while (k < 4 && n < 30) begin
      if (o_Ready) begin
        i_Cod_op = 3'(ops[k]); i_Arguments = 6'(args[k]);
        if (k == 3) pc_at4 = int'(o_PC);
      end else begin
        // an always-taken jump to 0 that must never be picked up
        i_Cod_op = 3'd6; i_Arguments = 6'd0;
      end
      rdy = o_Ready;
      step();
      n++;
      if (rdy) begin acc_t[k] = cyc; k++; end
    end
    i_Instr_Valid = 1'b0;
    chk("b2b_count", k, 4);
    chk("b2b_gap0", acc_t[1] - acc_t[0], 2);
    chk("b2b_gap1", acc_t[2] - acc_t[1], 2);
    chk("b2b_gap2", acc_t[3] - acc_t[2], 3);
    chk("b2b_pc3", pc_at4, (p0 + 3) % 256);
    step();
    exp_pc = (p0 + 4) % 256;
    chk("b2b_pc4", o_PC, exp_pc);
    chk("b2b_ready", o_Ready, 1);

    // randomized instructions against the model
    for (int i = 0; i < 40; i++)
      run_instr($urandom_range(0, 7), $urandom_range(0, 63), 2'($urandom_range(0, 3)));

    // PC wrap
    do_reset();
    for (int i = 0; i < 256; i++)
      run_instr(7, $urandom_range(0, 63), 2'($urandom_range(0, 3)));
    chk("wrap_pc", o_PC, 0);

    // reset during WB of a MOVE
    run_instr(7, 0, 2'b00);
    run_instr(7, 0, 2'b00);
    chk("pre_rst_pc", o_PC, 2);
    i_Instr_Valid = 1'b1; i_Cod_op = 3'd4; i_Arguments = 6'($urandom_range(0, 63));
    step();
    i_Instr_Valid = 1'b0;
    step();
    chk("rstwb_in_wb", o_Wr_En, 1);
    i_Rst = 1'b1;
    step();
    chk("rstwb_ctrl", act, 0);
    chk("rstwb_pc", o_PC, 0);
    chk("rstwb_ready", o_Ready, 0);
    i_Rst = 1'b0;
    #1;
    chk("rstwb_ready_after", o_Ready, 1);
    step();
    chk("rstwb_idle_pc", o_PC, 0);
    chk("rstwb_idle_ctrl", act, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
